// File: rtl/lamp_pkg.sv
// Shared definitions for the traffic-lamp monitor.
//   - one-hot lamp codes as they appear on the light bus
//   - colour indices produced by the decoder (11 = none/invalid)
//   - monitor state encoding (IDLE, ACQ, LOCK)
//   - next_idx(): legal successor colour, RED -> GREEN -> YELLOW -> RED
package lamp_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    localparam logic [1:0] IDX_RED    = 2'b00;
    localparam logic [1:0] IDX_GREEN  = 2'b01;
    localparam logic [1:0] IDX_YELLOW = 2'b10;
    localparam logic [1:0] IDX_NONE   = 2'b11;

    typedef logic [1:0] mon_state_t;
    localparam mon_state_t ST_IDLE = 2'd0;
    localparam mon_state_t ST_ACQ  = 2'd1;
    localparam mon_state_t ST_LOCK = 2'd2;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            IDX_RED:    nxt = IDX_GREEN;
            IDX_GREEN:  nxt = IDX_YELLOW;
            IDX_YELLOW: nxt = IDX_RED;
            default:    nxt = IDX_NONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/lamp_decode.sv
// Combinational one-hot lamp bus decoder.
// Ports:
//   light : lamp bus, RED=3'b100, GREEN=3'b010, YELLOW=3'b001
//   idx   : colour index (00 red, 01 green, 10 yellow, 11 none)
//   valid : high when light carries exactly one of the three legal codes
module lamp_decode
    import lamp_pkg::*;
(
    input  logic [0:2] light,
    output logic [1:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = IDX_NONE;
        valid = 1'b0;
        case (light)
            LAMP_RED:    begin idx = IDX_RED;    valid = 1'b1; end
            LAMP_GREEN:  begin idx = IDX_GREEN;  valid = 1'b1; end
            LAMP_YELLOW: begin idx = IDX_YELLOW; valid = 1'b1; end
            default:     begin idx = IDX_NONE;   valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/lamp_sequence_monitor.sv
// Receive-side protocol monitor for the cyclic traffic-lamp controller.
// Samples the one-hot light bus every rising edge, checks the order
// RED -> GREEN -> YELLOW -> RED and the per-colour dwell, locks after
// LOCK_COUNT consecutive good transitions and counts YELLOW->RED cycles.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   light        : lamp bus (one-hot)
//   clear_errs   : synchronous clear of the sticky error flags
//   color        : registered decode of the last sample (11 = invalid)
//   locked       : high while in LOCK
//   cycle_count  : good YELLOW->RED transitions, wraps
//   err_onehot / err_order / err_dwell : sticky error flags
//   err_pulse    : one-cycle strobe for every newly detected error
//   state        : debug view of the monitor state
// All outputs are registered and reflect the sample of the last edge.
module lamp_sequence_monitor
    import lamp_pkg::*;
#(
    parameter int DWELL      = 1,
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:2]       light,
    input  logic             clear_errs,
    output logic [1:0]       color,
    output logic             locked,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_dwell,
    output logic             err_pulse,
    output logic [1:0]       state
);

    localparam int DW_W   = $clog2(DWELL + 2);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [DW_W-1:0]   DW_ONE   = DW_W'(1);
    localparam logic [DW_W-1:0]   DW_REQ   = DW_W'(DWELL);
    localparam logic [DW_W-1:0]   DW_MAX   = DW_W'(DWELL + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

    logic [1:0]        s_idx;
    logic              s_valid;

    mon_state_t        state_q, state_n;
    logic [DW_W-1:0]   dwell_q, dwell_n;
    logic [GOOD_W-1:0] good_q, good_n, good_inc;
    // partial: the current colour run started mid-phase (after acquisition,
    // an order error or an over-long dwell), so its length cannot be judged
    logic              partial_q, partial_n;
    logic              cnt_inc;
    logic              new_onehot, new_order, new_dwell;

    lamp_decode u_decode (
        .light (light),
        .idx   (s_idx),
        .valid (s_valid)
    );

    always_comb begin
        state_n    = state_q;
        dwell_n    = dwell_q;
        good_n     = good_q;
        partial_n  = partial_q;
        cnt_inc    = 1'b0;
        new_onehot = 1'b0;
        new_order  = 1'b0;
        new_dwell  = 1'b0;
        good_inc   = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;

        if (!s_valid) begin
            new_onehot = 1'b1;
            state_n    = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_n   = ST_ACQ;
            dwell_n   = DW_ONE;
            good_n    = '0;
            partial_n = 1'b1;
        end else if (s_idx == color) begin
            // Error fires only on the step into DWELL+1; once saturated
            // the counter stays put and no further error is raised.
            if (dwell_q == DW_REQ) begin
                dwell_n   = DW_MAX;
                new_dwell = 1'b1;
                state_n   = ST_ACQ;
                good_n    = '0;
                partial_n = 1'b1;
            end else if (dwell_q != DW_MAX) begin
                dwell_n = dwell_q + 1'b1;
            end
        end else if (s_idx == next_idx(color)) begin
            dwell_n   = DW_ONE;
            partial_n = 1'b0;
            if (!partial_q && (dwell_q < DW_REQ)) begin
                new_dwell = 1'b1;
                state_n   = ST_ACQ;
                good_n    = '0;
            end else begin
                good_n  = good_inc;
                cnt_inc = (color == IDX_YELLOW);
                if (good_inc == GOOD_MAX) begin
                    state_n = ST_LOCK;
                end
            end
        end else begin
            new_order = 1'b1;
            state_n   = ST_ACQ;
            good_n    = '0;
            partial_n = 1'b1;
            dwell_n   = DW_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            color       <= IDX_NONE;
            dwell_q     <= '0;
            good_q      <= '0;
            partial_q   <= 1'b1;
            cycle_count <= '0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            err_dwell   <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            state_q   <= state_n;
            color     <= s_idx;
            dwell_q   <= dwell_n;
            good_q    <= good_n;
            partial_q <= partial_n;
            if (cnt_inc) begin
                cycle_count <= cycle_count + 1'b1;
            end
            // A newly detected error wins over a simultaneous clear.
            err_onehot <= (err_onehot & ~clear_errs) | new_onehot;
            err_order  <= (err_order  & ~clear_errs) | new_order;
            err_dwell  <= (err_dwell  & ~clear_errs) | new_dwell;
            err_pulse  <= new_onehot | new_order | new_dwell;
        end
    end

    assign locked = (state_q == ST_LOCK);
    assign state  = state_q;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
module tb_lamp_sequence_monitor;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] G  = 3'b010;
    localparam logic [2:0] Y  = 3'b001;
    localparam logic [2:0] BAD = 3'b110;
    localparam int LC = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:2] light;
    logic       clear_errs;

    logic [1:0] col_o [3];
    logic       lk_o  [3];
    logic       eoh_o [3];
    logic       eor_o [3];
    logic       edw_o [3];
    logic       p_o   [3];
    logic [1:0] st_o  [3];
    logic [7:0] c1_o, c2_o;
    logic [1:0] c3_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // d1: DWELL=1, d2: DWELL=2, d3: DWELL=1 with a 2-bit cycle counter
    lamp_sequence_monitor #(.DWELL(1), .LOCK_COUNT(LC), .CNT_W(8)) d1 (
        .clk(clk), .rst(rst), .light(light), .clear_errs(clear_errs),
        .color(col_o[0]), .locked(lk_o[0]), .cycle_count(c1_o),
        .err_onehot(eoh_o[0]), .err_order(eor_o[0]), .err_dwell(edw_o[0]),
        .err_pulse(p_o[0]), .state(st_o[0]));
    lamp_sequence_monitor #(.DWELL(2), .LOCK_COUNT(LC), .CNT_W(8)) d2 (
        .clk(clk), .rst(rst), .light(light), .clear_errs(clear_errs),
        .color(col_o[1]), .locked(lk_o[1]), .cycle_count(c2_o),
        .err_onehot(eoh_o[1]), .err_order(eor_o[1]), .err_dwell(edw_o[1]),
        .err_pulse(p_o[1]), .state(st_o[1]));
    lamp_sequence_monitor #(.DWELL(1), .LOCK_COUNT(LC), .CNT_W(2)) d3 (
        .clk(clk), .rst(rst), .light(light), .clear_errs(clear_errs),
        .color(col_o[2]), .locked(lk_o[2]), .cycle_count(c3_o),
        .err_onehot(eoh_o[2]), .err_order(eor_o[2]), .err_dwell(edw_o[2]),
        .err_pulse(p_o[2]), .state(st_o[2]));

    // ---------------- reference model ----------------
    // Tracks the unbounded length of the current colour run and the
    // number of consecutive good transitions; locked = synced and
    // at least LC good transitions since the last disturbance.
    typedef struct {
        bit synced;
        int col;
        int run;
        int good;
        bit partial;
        int cnt;
        bit e_oh, e_or, e_dw, pulse;
    } mdl_t;

    mdl_t m [3];
    int dw_p [3] = '{1, 2, 1};
    int cw_p [3] = '{8, 8, 2};

    function automatic int idx_of(logic [2:0] l);
        if (l == R) return 0;
        if (l == G) return 1;
        if (l == Y) return 2;
        return 3;
    endfunction

    function automatic logic [2:0] code_of(int idx);
        if (idx == 0) return R;
        if (idx == 1) return G;
        return Y;
    endfunction

    function automatic mdl_t mreset();
        mdl_t s;
        s.synced = 0; s.col = 3; s.run = 0; s.good = 0; s.partial = 1;
        s.cnt = 0; s.e_oh = 0; s.e_or = 0; s.e_dw = 0; s.pulse = 0;
        return s;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int dw, int cw, logic [2:0] l, logic clr);
        int idx;
        bit no, nr, nd;
        idx = idx_of(l);
        no = 0; nr = 0; nd = 0;
        if (idx == 3) begin
            no = 1; s.synced = 0; s.good = 0;
        end else if (!s.synced) begin
            s.synced = 1; s.run = 1; s.good = 0; s.partial = 1;
        end else if (idx == s.col) begin
            s.run = s.run + 1;
            if (s.run == dw + 1) begin
                nd = 1; s.good = 0; s.partial = 1;
            end
        end else if (idx == (s.col + 1) % 3) begin
            if (!s.partial && s.run < dw) begin
                nd = 1; s.good = 0;
            end else begin
                s.good = s.good + 1;
                if (s.col == 2) s.cnt = (s.cnt + 1) % (1 << cw);
            end
            s.partial = 0; s.run = 1;
        end else begin
            nr = 1; s.good = 0; s.partial = 1; s.run = 1;
        end
        s.col   = idx;
        s.e_oh  = (s.e_oh && !clr) || no;
        s.e_or  = (s.e_or && !clr) || nr;
        s.e_dw  = (s.e_dw && !clr) || nd;
        s.pulse = no || nr || nd;
        return s;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(int k);
        if (k == 0) return {24'd0, c1_o};
        if (k == 1) return {24'd0, c2_o};
        return {30'd0, c3_o};
    endfunction

    task automatic chk_model(int k);
        chk($sformatf("d%0d color", k),  {30'd0, col_o[k]}, m[k].col);
        chk($sformatf("d%0d locked", k), {31'd0, lk_o[k]},
            (m[k].synced && m[k].good >= LC) ? 1 : 0);
        chk($sformatf("d%0d count", k),  cnt_of(k), m[k].cnt);
        chk($sformatf("d%0d err_onehot", k), {31'd0, eoh_o[k]}, {31'd0, m[k].e_oh});
        chk($sformatf("d%0d err_order", k),  {31'd0, eor_o[k]}, {31'd0, m[k].e_or});
        chk($sformatf("d%0d err_dwell", k),  {31'd0, edw_o[k]}, {31'd0, m[k].e_dw});
        chk($sformatf("d%0d err_pulse", k),  {31'd0, p_o[k]},   {31'd0, m[k].pulse});
    endtask

    task automatic chk_reset_vals(string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s d%0d color", tag, k), {30'd0, col_o[k]}, 3);
            chk($sformatf("%s d%0d locked", tag, k), {31'd0, lk_o[k]}, 0);
            chk($sformatf("%s d%0d count", tag, k), cnt_of(k), 0);
            chk($sformatf("%s d%0d errs", tag, k),
                {29'd0, eoh_o[k], eor_o[k], edw_o[k]}, 0);
            chk($sformatf("%s d%0d pulse", tag, k), {31'd0, p_o[k]}, 0);
            chk($sformatf("%s d%0d state", tag, k), {30'd0, st_o[k]}, 0);
        end
    endtask

    // Drive one sample, let it be captured, update the model, compare.
    task automatic step(logic [2:0] l, logic clr);
        light      = l;
        clear_errs = clr;
        @(posedge clk);
        for (int k = 0; k < 3; k++) m[k] = mstep(m[k], dw_p[k], cw_p[k], l, clr);
        #1;
        for (int k = 0; k < 3; k++) chk_model(k);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic reset_pulse(string tag);
        rst = 1'b1;
        #2;
        chk_reset_vals(tag);
        for (int k = 0; k < 3; k++) m[k] = mreset();
        rst = 1'b0;
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0] l;
        logic       clr;
        logic [1:0] color;
        logic       locked;
        logic [7:0] cnt;
        logic [2:0] errs;   // {onehot, order, dwell}
        logic       pulse;
        logic [1:0] st;
    } vec_t;

    vec_t vecs [18];
    logic [1:0] exp_q [$];

    initial begin
        // cycle / order / onehot / clear behaviour on d1 (DWELL=1)
        vecs[0]  = '{R,   0, 2'b00, 0, 8'd0, 3'b000, 0, 2'd1};
        vecs[1]  = '{G,   0, 2'b01, 0, 8'd0, 3'b000, 0, 2'd1};
        vecs[2]  = '{Y,   0, 2'b10, 0, 8'd0, 3'b000, 0, 2'd1};
        vecs[3]  = '{R,   0, 2'b00, 1, 8'd1, 3'b000, 0, 2'd2};
        vecs[4]  = '{G,   0, 2'b01, 1, 8'd1, 3'b000, 0, 2'd2};
        vecs[5]  = '{Y,   0, 2'b10, 1, 8'd1, 3'b000, 0, 2'd2};
        vecs[6]  = '{R,   0, 2'b00, 1, 8'd2, 3'b000, 0, 2'd2};
        vecs[7]  = '{Y,   0, 2'b10, 0, 8'd2, 3'b010, 1, 2'd1};
        vecs[8]  = '{R,   0, 2'b00, 0, 8'd3, 3'b010, 0, 2'd1};
        vecs[9]  = '{G,   0, 2'b01, 0, 8'd3, 3'b010, 0, 2'd1};
        vecs[10] = '{Y,   0, 2'b10, 1, 8'd3, 3'b010, 0, 2'd2};
        vecs[11] = '{BAD, 0, 2'b11, 0, 8'd3, 3'b110, 1, 2'd0};
        vecs[12] = '{R,   0, 2'b00, 0, 8'd3, 3'b110, 0, 2'd1};
        vecs[13] = '{G,   0, 2'b01, 0, 8'd3, 3'b110, 0, 2'd1};
        vecs[14] = '{Y,   0, 2'b10, 0, 8'd3, 3'b110, 0, 2'd1};
        vecs[15] = '{R,   0, 2'b00, 1, 8'd4, 3'b110, 0, 2'd2};
        vecs[16] = '{Y,   1, 2'b10, 0, 8'd4, 3'b010, 1, 2'd1};
        vecs[17] = '{R,   1, 2'b00, 0, 8'd5, 3'b000, 0, 2'd1};

        rst = 1'b1;
        light = 3'b000;
        clear_errs = 1'b0;
        #1;
        chk_reset_vals("por");
        for (int k = 0; k < 3; k++) m[k] = mreset();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].l, vecs[i].clr);
            chk($sformatf("vec%0d color", i),  {30'd0, col_o[0]}, {30'd0, vecs[i].color});
            chk($sformatf("vec%0d locked", i), {31'd0, lk_o[0]},  {31'd0, vecs[i].locked});
            chk($sformatf("vec%0d count", i),  {24'd0, c1_o},     {24'd0, vecs[i].cnt});
            chk($sformatf("vec%0d errs", i),
                {29'd0, eoh_o[0], eor_o[0], edw_o[0]}, {29'd0, vecs[i].errs});
            chk($sformatf("vec%0d pulse", i),  {31'd0, p_o[0]},   {31'd0, vecs[i].pulse});
            chk($sformatf("vec%0d state", i),  {30'd0, st_o[0]},  {30'd0, vecs[i].st});
        end

        // dwell checks on d2 (DWELL=2)
        reset_pulse("rst_a");
        step(R, 0); step(R, 0); step(G, 0); step(G, 0);
        step(Y, 0); step(Y, 0); step(R, 0); step(R, 0);
        chk("dw2 locked", {31'd0, lk_o[1]}, 1);
        chk("dw2 count", {24'd0, c2_o}, 1);
        step(G, 0); step(G, 0);
        chk("dw2 long pre", {31'd0, edw_o[1]}, 0);
        step(G, 0);
        chk("dw2 long err", {31'd0, edw_o[1]}, 1);
        chk("dw2 long pulse", {31'd0, p_o[1]}, 1);
        chk("dw2 long unlock", {31'd0, lk_o[1]}, 0);
        step(Y, 0); step(Y, 0); step(R, 0); step(R, 0);
        step(G, 1);
        chk("dw2 relock", {31'd0, lk_o[1]}, 1);
        chk("dw2 cleared", {31'd0, edw_o[1]}, 0);
        step(Y, 0);
        chk("dw2 short err", {31'd0, edw_o[1]}, 1);
        chk("dw2 short pulse", {31'd0, p_o[1]}, 1);
        chk("dw2 short unlock", {31'd0, lk_o[1]}, 0);

        // counter wrap on d3 (CNT_W=2)
        reset_pulse("rst_b");
        step(R, 0); step(G, 0); step(Y, 0); step(R, 0);
        chk("wrap locked", {31'd0, lk_o[2]}, 1);
        chk("wrap first", {30'd0, c3_o}, 1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] e;
            step(G, 0); step(Y, 0); step(R, 0);
            e = exp_q.pop_front();
            chk($sformatf("wrap cyc%0d", i), {30'd0, c3_o}, {30'd0, e});
        end
        chk("pre-reset locked", {31'd0, lk_o[0]}, 1);
        reset_pulse("rst_locked");

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [2:0] l;
            r = $urandom_range(0, 9);
            if (r <= 4)      l = code_of((m[0].col == 3) ? 0 : (m[0].col + 1) % 3);
            else if (r <= 7) l = (m[0].col == 3) ? R : code_of(m[0].col);
            else if (r == 8) l = code_of($urandom_range(0, 2));
            else             l = 3'($urandom_range(0, 7));
            step(l, ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
